// File: rtl/uart_frame_pkg.sv
// Shared types, ASCII constants and the 7-segment digit table for the UART
// frame controller.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ARM,
        T_LOAD,
        T_WAIT
    } tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segments a..g from MSB to LSB, active-low.
    function automatic logic [6:0] seg7_of(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_eol(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-level link between the frame controller and the uartWrite/uartRead
// instances.
interface uart_frame_ctrl_if;
    // TX: controller drops tx_run and waits for tx_fb=0 (armed), then raises
    // tx_run with tx_data stable until tx_fb=1 (byte done).
    // RX: rx_data is valid while rx_fb=1; each rising edge of rx_fb is one byte.
    logic       tx_fb;
    logic       tx_run;
    logic [7:0] tx_data;
    logic       rx_fb;
    logic [7:0] rx_data;

    modport master (
        output tx_run,
        output tx_data,
        input  tx_fb,
        input  rx_fb,
        input  rx_data
    );

    modport slave (
        input  tx_run,
        input  tx_data,
        output tx_fb,
        output rx_fb,
        output rx_data
    );
endinterface

// File: rtl/ascii_seg7_dec.sv
// Combinational ASCII digit to active-low 7-segment decoder; any non-digit
// byte shows blank.
module ascii_seg7_dec
    import uart_frame_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [6:0] seg
);

    // '0'..'9' carry their value in the low nibble.
    always_comb begin
        seg = SEG_BLANK;
        if (is_digit(ascii)) begin
            seg = seg7_of(ascii[3:0]);
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART banner/echo transmitter and digit-frame receiver driving N_DIGITS
// active-low 7-segment displays.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int                   MSG_LEN     = 16,
    parameter logic [8*MSG_LEN-1:0] MSG         = "** Thanh Hung **",
    parameter int                   N_DIGITS    = 4,
    parameter int                   TIMEOUT_CYC = 50000,
    parameter bit                   ECHO        = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    uart_frame_ctrl_if.master       uart,
    input  logic                    send_req,
    output logic [7*N_DIGITS-1:0]   seg,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    tx_busy,
    output tx_state_t               tx_state
);

    localparam int MAX_JOB = (MSG_LEN > N_DIGITS + 2) ? MSG_LEN : N_DIGITS + 2;
    localparam int IDX_W   = $clog2(MAX_JOB);
    localparam int CNT_W   = $clog2(N_DIGITS + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int IMG_W   = 8 * MAX_JOB;

    localparam logic [IDX_W-1:0] BANNER_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(N_DIGITS);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    // Banner left-aligned in the job shift register, byte 0 on top.
    localparam logic [IMG_W-1:0] BANNER_IMG  = IMG_W'(MSG) << (8 * (MAX_JOB - MSG_LEN));

    // ---------------- RX frame assembly ----------------
    logic             rx_fb_q;
    logic             rx_ev;
    logic             rx_is_digit;
    logic             rx_is_eol;
    logic             frame_open;
    logic             timeout_hit;
    logic             close_frame;
    logic             accept;
    logic             store_digit;
    logic [CNT_W-1:0] wr_ptr;
    logic             ovf;
    logic             bad;
    logic [TO_W-1:0]  idle_cnt;
    logic [7:0]       rx_buf [N_DIGITS];
    logic [7:0]       cm_buf [N_DIGITS];
    logic [CNT_W-1:0] cm_cnt;

    always_comb begin
        rx_ev       = uart.rx_fb & ~rx_fb_q;
        rx_is_digit = is_digit(uart.rx_data);
        rx_is_eol   = is_eol(uart.rx_data);
        frame_open  = (wr_ptr != '0) | ovf | bad;
        // A byte arriving on the timeout cycle keeps the frame open.
        timeout_hit = frame_open & ~rx_ev & (idle_cnt == TO_LAST);
        close_frame = timeout_hit | (rx_ev & rx_is_eol & frame_open);
        accept      = close_frame & ~ovf & ~bad;
        store_digit = rx_ev & rx_is_digit & (wr_ptr != CNT_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_fb_q     <= 1'b0;
            wr_ptr      <= '0;
            ovf         <= 1'b0;
            bad         <= 1'b0;
            idle_cnt    <= '0;
            cm_buf      <= '{default: '0};
            cm_cnt      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_fb_q     <= uart.rx_fb;
            frame_valid <= accept;
            frame_err   <= close_frame & ~accept;
            idle_cnt    <= (rx_ev | ~frame_open | timeout_hit) ? '0 : idle_cnt + TO_W'(1);
            if (close_frame) begin
                wr_ptr <= '0;
                ovf    <= 1'b0;
                bad    <= 1'b0;
                if (accept) begin
                    cm_buf <= rx_buf;
                    cm_cnt <= wr_ptr;
                end
            end else if (rx_ev) begin
                if (store_digit) begin
                    wr_ptr <= wr_ptr + CNT_W'(1);
                end else if (rx_is_digit) begin
                    ovf <= 1'b1;
                end else if (!rx_is_eol) begin
                    bad <= 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < N_DIGITS; p++) begin : g_rx_buf
        always_ff @(posedge clock) begin
            if (reset) begin
                rx_buf[p] <= '0;
            end else if (store_digit && (wr_ptr == CNT_W'(p))) begin
                rx_buf[p] <= uart.rx_data;
            end
        end
    end

    // Digits beyond the committed length are fed a non-digit and show blank.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_seg
        logic [7:0] ch;
        assign ch = (k < int'(cm_cnt)) ? cm_buf[k] : 8'h00;
        ascii_seg7_dec u_dec (
            .ascii (ch),
            .seg   (seg[7*k +: 7])
        );
    end

    // ---------------- TX job sequencing ----------------
    tx_state_t        state;
    tx_state_t        state_nxt;
    logic             job_start;
    logic             byte_done;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [IMG_W-1:0] job_sr;
    logic [IMG_W-1:0] echo_img;
    logic [7:0]       tx_data_q;
    logic             banner_pend;
    logic             echo_pend;

    // Echo payload: committed digits, then CR LF, left-aligned.
    for (genvar p = 0; p < MAX_JOB; p++) begin : g_echo_img
        logic [7:0] dig;
        if (p < N_DIGITS) begin : g_dig
            assign dig = cm_buf[p];
        end else begin : g_pad
            assign dig = 8'h00;
        end
        assign echo_img[IMG_W-8-8*p +: 8] =
            (p <  int'(cm_cnt))     ? dig      :
            (p == int'(cm_cnt))     ? ASCII_CR :
            (p == int'(cm_cnt) + 1) ? ASCII_LF : 8'h00;
    end

    always_comb begin
        state_nxt = state;
        job_start = 1'b0;
        byte_done = 1'b0;
        case (state)
            T_IDLE: begin
                if (banner_pend || echo_pend) begin
                    job_start = 1'b1;
                    state_nxt = T_ARM;
                end
            end
            T_ARM: begin
                if (!uart.tx_fb) state_nxt = T_LOAD;
            end
            T_LOAD: begin
                state_nxt = T_WAIT;
            end
            T_WAIT: begin
                if (uart.tx_fb) begin
                    byte_done = 1'b1;
                    state_nxt = (idx == last_idx) ? T_IDLE : T_ARM;
                end
            end
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= T_IDLE;
            idx         <= '0;
            last_idx    <= '0;
            job_sr      <= '0;
            tx_data_q   <= '0;
            banner_pend <= 1'b1;
            echo_pend   <= 1'b0;
        end else begin
            state <= state_nxt;
            // The echo image is latched here, so later commits cannot alter a running echo.
            if (job_start) begin
                idx <= '0;
                if (banner_pend) begin
                    job_sr   <= BANNER_IMG;
                    last_idx <= BANNER_LAST;
                end else begin
                    job_sr   <= echo_img;
                    last_idx <= IDX_W'(cm_cnt) + IDX_W'(1);
                end
            end else if (byte_done && (idx != last_idx)) begin
                idx    <= idx + IDX_W'(1);
                job_sr <= job_sr << 8;
            end
            if ((state == T_ARM) && !uart.tx_fb) begin
                tx_data_q <= job_sr[IMG_W-1 -: 8];
            end
            if (send_req) begin
                banner_pend <= 1'b1;
            end else if (job_start) begin
                banner_pend <= 1'b0;
            end
            if (accept && ECHO) begin
                echo_pend <= 1'b1;
            end else if (job_start && !banner_pend) begin
                echo_pend <= 1'b0;
            end
        end
    end

    assign uart.tx_run  = (state == T_LOAD) || (state == T_WAIT);
    assign uart.tx_data = tx_data_q;
    assign tx_busy      = (state != T_IDLE);
    assign tx_state     = state;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a behavioural uartWrite model and
// an expected-byte queue for everything transmitted.
module tb_uart_frame_ctrl;
    import uart_frame_pkg::*;

    localparam int N_DIGITS    = 4;
    localparam int TIMEOUT_CYC = 64;

    localparam logic [27:0] SEG_ALL_BLANK = 28'hFFFFFFF;
    localparam logic [27:0] SEG_1234 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    localparam logic [27:0] SEG_57   = {7'b1111111, 7'b1111111, 7'b0001111, 7'b0100100};

    // ---------------- clock / reset ----------------
    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        send_req = 1'b0;
    logic [27:0] seg;
    logic        frame_valid;
    logic        frame_err;
    logic        tx_busy;
    tx_state_t   tx_state;

    always #10 clock = ~clock;

    uart_frame_ctrl_if uart ();

    uart_frame_ctrl #(
        .MSG_LEN     (16),
        .MSG         ("** Thanh Hung **"),
        .N_DIGITS    (N_DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ECHO        (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart        (uart),
        .send_req    (send_req),
        .seg         (seg),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .tx_busy     (tx_busy),
        .tx_state    (tx_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_tx    = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic [7:0] exp_q[$];
    logic       run_d   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uartWrite model: armed two cycles after run drops, done ten cycles after run rises.
    int hi_cnt = 0;
    int lo_cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            uart.tx_fb <= 1'b1;
            hi_cnt     <= 0;
            lo_cnt     <= 0;
        end else if (uart.tx_run) begin
            lo_cnt <= 0;
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt == 9) uart.tx_fb <= 1'b1;
        end else begin
            hi_cnt <= 0;
            lo_cnt <= lo_cnt + 1;
            if (lo_cnt == 1) uart.tx_fb <= 1'b0;
        end
    end

    // Each tx_run rise carries one byte; compare it against the queue head.
    always @(negedge clock) begin
        if (uart.tx_run && !run_d) begin
            n_tx++;
            if (exp_q.size() == 0) check_eq("tx_extra_byte", 64'(uart.tx_data), 64'h100);
            else check_eq("tx_byte", 64'(uart.tx_data), 64'(exp_q.pop_front()));
        end
        run_d = uart.tx_run;
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_echo(input string s);
        push_str(s);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        uart.rx_data = b;
        uart.rx_fb   = 1'b1;
        tick(3);
        uart.rx_fb   = 1'b0;
        tick(3);
    endtask

    task automatic rx_str(input string s);
        for (int i = 0; i < s.len(); i++) rx_byte(s[i]);
    endtask

    task automatic pulse_send_req;
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        int quiet;
        int cyc;
        quiet = 0;
        cyc   = 0;
        while (quiet < 20 && cyc < 6000) begin
            tick(1);
            cyc++;
            if (tx_busy || exp_q.size() != 0) quiet = 0;
            else quiet++;
        end
        check_eq({tag, "_settled"}, 64'(quiet >= 20), 64'd1);
        check_eq({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    int v0, e0, t0, cyc;

    initial begin
        uart.rx_fb   = 1'b0;
        uart.rx_data = 8'h00;
        tick(4);

        check_eq("rst_tx_run", 64'(uart.tx_run), 64'd0);
        check_eq("rst_tx_data", 64'(uart.tx_data), 64'd0);
        check_eq("rst_seg", 64'(seg), 64'(SEG_ALL_BLANK));
        check_eq("rst_valid", 64'(frame_valid), 64'd0);
        check_eq("rst_err", 64'(frame_err), 64'd0);
        check_eq("rst_busy", 64'(tx_busy), 64'd0);
        check_eq("rst_state", 64'(tx_state), 64'(T_IDLE));

        // Banner after reset release.
        push_str("** Thanh Hung **");
        reset = 1'b0;
        wait_tx_done("boot_banner");
        check_eq("boot_banner_bytes", 64'(n_tx), 64'd16);
        check_eq("boot_busy", 64'(tx_busy), 64'd0);

        // CR-terminated frame with echo.
        v0 = n_valid; e0 = n_err;
        push_echo("1234");
        rx_str("1234");
        rx_byte(8'h0D);
        check_eq("seg_1234", 64'(seg), 64'(SEG_1234));
        check_eq("valid_1234", 64'(n_valid - v0), 64'd1);
        check_eq("err_1234", 64'(n_err - e0), 64'd0);
        wait_tx_done("echo_1234");

        // Timeout-closed frame; nothing before the idle window expires.
        v0 = n_valid;
        push_echo("57");
        rx_str("57");
        tick(TIMEOUT_CYC - 12);
        check_eq("no_early_timeout", 64'(n_valid - v0), 64'd0);
        check_eq("seg_hold_before_to", 64'(seg), 64'(SEG_1234));
        tick(20);
        check_eq("seg_57", 64'(seg), 64'(SEG_57));
        check_eq("valid_57", 64'(n_valid - v0), 64'd1);
        wait_tx_done("echo_57");

        // Rejected frames: bad character, then overflow.
        v0 = n_valid; e0 = n_err;
        rx_str("12a4");
        rx_byte(8'h0D);
        check_eq("err_bad_char", 64'(n_err - e0), 64'd1);
        check_eq("seg_keep_bad", 64'(seg), 64'(SEG_57));
        rx_str("12345");
        rx_byte(8'h0D);
        check_eq("err_overflow", 64'(n_err - e0), 64'd2);
        check_eq("valid_none_rejects", 64'(n_valid - v0), 64'd0);
        check_eq("seg_keep_ovf", 64'(seg), 64'(SEG_57));
        wait_tx_done("no_echo_rejects");

        // Requests during a banner collapse into one extra banner.
        t0 = n_tx;
        push_str("** Thanh Hung **");
        push_str("** Thanh Hung **");
        pulse_send_req();
        tick(40);
        pulse_send_req();
        tick(30);
        pulse_send_req();
        wait_tx_done("banner_twice");
        check_eq("banner_twice_bytes", 64'(n_tx - t0), 64'd32);

        // A lone CR on an empty frame is ignored.
        v0 = n_valid; e0 = n_err;
        rx_byte(8'h0D);
        tick(5);
        check_eq("lone_cr_valid", 64'(n_valid - v0), 64'd0);
        check_eq("lone_cr_err", 64'(n_err - e0), 64'd0);
        check_eq("lone_cr_seg", 64'(seg), 64'(SEG_57));

        // Reset while byte 7 of the banner is on the wire.
        t0 = n_tx;
        push_str("** Thanh Hung **");
        pulse_send_req();
        cyc = 0;
        while (n_tx < t0 + 8 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        check_eq("reach_byte7", 64'(n_tx - t0), 64'd8);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_tx_run", 64'(uart.tx_run), 64'd0);
        check_eq("midrst_seg", 64'(seg), 64'(SEG_ALL_BLANK));
        check_eq("midrst_busy", 64'(tx_busy), 64'd0);
        exp_q.delete();
        push_str("** Thanh Hung **");
        t0 = n_tx;
        tick(2);
        reset = 1'b0;
        wait_tx_done("banner_restart");
        check_eq("banner_restart_bytes", 64'(n_tx - t0), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
